// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, FUNCT3 encodings, fault causes and the acceptance fault check
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [1:0] FC_NONE = 2'b00, FC_MISALIGN = 2'b01, FC_ILLEGAL = 2'b10, FC_TIMEOUT = 2'b11;
  // illegal encoding outranks misalignment; stores have no unsigned variants
  function automatic logic [1:0] check_fault(logic [2:0] f3, logic [1:0] off, logic wr);
    logic illegal, misal;
    illegal = wr ? !(f3 inside {F3_B, F3_H, F3_W}) : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal = ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
    return illegal ? FC_ILLEGAL : misal ? FC_MISALIGN : FC_NONE;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave)
interface load_store_unit_if;
  logic req, we, gnt, rvalid;
  logic [3:0] be;
  logic [31:0] addr, wdata, rdata;
  modport master(output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store byte-lane steering/replication and load shift plus sign/zero extension
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [31:0] sh;
  // width comes from funct3[1:0]; funct3[2] only selects zero-extension on loads
  always_comb begin
    sh = rdata_i >> {offset_i, 3'b000};
    be_o = funct3_i[1:0] == 2'b00 ? 4'b0001 << offset_i :
           funct3_i[1:0] == 2'b01 ? 4'b0011 << {offset_i[1], 1'b0} : 4'hF;
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
              funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = funct3_i == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
              funct3_i == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
              funct3_i == F3_BU ? {24'h0, sh[7:0]} :
              funct3_i == F3_HU ? {16'h0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store stage with req/gnt/rvalid memory handshake; LSU_TIMEOUT_EN bounds WAIT
module load_store_unit import lsu_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  load_store_unit_if.master dm
);
  state_e state_q;
  logic write_q, busy_q, done_q, fault_q, accept, fin, tmo;
  logic [2:0] f3_q;
  logic [1:0] fc_q, cause_q, accept_fc, fin_cause;
  logic [31:0] addr_q, wdata_q, rdata_q, wdata_rep, rdata_ext, fin_data;
  logic [3:0] be;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  lsu_align u_align (
    .funct3_i(f3_q), .offset_i(addr_q[1:0]), .wdata_i(wdata_q), .rdata_i(dm.rdata),
    .be_o(be), .wdata_o(wdata_rep), .rdata_o(rdata_ext)
  );
  assign accept = state_q == IDLE && start_i && (mem_read_i != mem_write_i);
  assign accept_fc = check_fault(funct3_i, addr_i[1:0], mem_write_i);
  assign dm.req = state_q == REQ;
  assign dm.we = dm.req && write_q;
  assign dm.be = dm.req ? (write_q ? be : 4'hF) : 4'h0;
  assign dm.addr = dm.req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dm.wdata = dm.we ? wdata_rep : 32'h0;
  assign {busy_o, done_o, rdata_o, fault_o, fault_cause_o} = {busy_q, done_q, rdata_q, fault_q, cause_q};
`ifdef LSU_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;
  assign tmo = state_q == WAIT && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // WAIT-cycle counter, zero everywhere else so it is clear on entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= state_q == WAIT ? cnt_q + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  // completion: store grant, load rvalid/timeout, or a fault parked in RESP without DONE yet
  always_comb begin
    fin = (state_q == REQ && dm.gnt && write_q) || (state_q == WAIT && (dm.rvalid || tmo)) ||
          (state_q == RESP && !done_q);
    fin_cause = state_q == RESP ? fc_q : (state_q == WAIT && !dm.rvalid) ? FC_TIMEOUT : FC_NONE;
    fin_data = (state_q == WAIT && dm.rvalid) ? rdata_ext : 32'h0;
  end
  // main FSM with registered core-side results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      {write_q, busy_q, done_q, fault_q} <= '0;
      f3_q <= '0;
      {fc_q, cause_q} <= '0;
      {addr_q, wdata_q, rdata_q} <= '0;
    end else begin
      done_q <= fin;
      if (fin) begin
        busy_q <= 1'b0;
        fault_q <= fin_cause != FC_NONE;
        cause_q <= fin_cause;
        rdata_q <= fin_data;
      end
      case (state_q)
        IDLE: if (accept) begin
          write_q <= mem_write_i;
          f3_q <= funct3_i;
          addr_q <= addr_i;
          wdata_q <= wdata_i;
          fc_q <= accept_fc;
          busy_q <= 1'b1;
          state_q <= accept_fc == FC_NONE ? REQ : RESP;
        end
        REQ: if (dm.gnt) state_q <= write_q ? RESP : WAIT;
        WAIT: if (fin) state_q <= RESP;
        default: if (done_q) state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level reference model
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0] funct3_i = 3'b0;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic busy_o, done_o, fault_o;
  logic [1:0] fault_cause_o;
  logic [31:0] rdata_o;
  int n_cmp = 0, n_err = 0;
  load_store_unit_if dm();
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .rdata_o(rdata_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o), .dm(dm)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] exp_cause(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'b10;
    if (a % size_of(f3) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = 4'h0;
    for (int k = 0; k < size_of(f3); k++) be[a % 4 + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] o;
    for (int k = 0; k < 4; k++) o[8*k +: 8] = w[8*(k % size_of(f3)) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    int n = size_of(f3);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(r[8*(a % 4 + k) +: 8]) << (8 * k);
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic xfer(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                      input int gd, input int rd, input logic [31:0] r);
    logic [1:0] fc = exp_cause(wr, f3, a);
    check("idle_busy", busy_o, 0);
    start_i = 1; mem_read_i = !wr; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = w;
    tick;
    start_i = 0; mem_read_i = 0; mem_write_i = 0;
    if (fc != 2'b00) begin
      check("flt_noreq", dm.req, 0);
      check("flt_busy", busy_o, 1);
      check("flt_early_done", done_o, 0);
      tick;
      check("flt_done", done_o, 1);
      check("flt_busy_off", busy_o, 0);
      check("flt_fault", fault_o, 1);
      check("flt_cause", fault_cause_o, fc);
      check("flt_rdata", rdata_o, 0);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        check("req", dm.req, 1);
        check("req_addr", dm.addr, a & ~32'h3);
        check("req_we", dm.we, wr);
        check("req_be", dm.be, wr ? exp_be(f3, a) : 4'hF);
        check("req_wdata", dm.wdata, wr ? exp_wdata(f3, w) : 32'h0);
        check("req_busy", busy_o, 1);
        check("req_done", done_o, 0);
        start_i = 1'($urandom % 2); mem_read_i = 1;
        dm.gnt = (i == gd);
        dm.rvalid = (i == gd) && ($urandom % 2 == 1);
        dm.rdata = $urandom;
        tick;
      end
      dm.gnt = 0; dm.rvalid = 0; start_i = 0; mem_read_i = 0;
      if (!wr) for (int j = 0; j <= rd; j++) begin
        check("wait_noreq", dm.req, 0);
        check("wait_done", done_o, 0);
        check("wait_busy", busy_o, 1);
        dm.rvalid = (j == rd);
        dm.rdata = (j == rd) ? r : $urandom;
        start_i = 1'($urandom % 2); mem_read_i = 1;
        tick;
      end
      dm.rvalid = 0; start_i = 0; mem_read_i = 0;
      check("done", done_o, 1);
      check("done_busy", busy_o, 0);
      check("done_fault", fault_o, 0);
      check("done_cause", fault_cause_o, 0);
      if (!wr) check("load_data", rdata_o, exp_load(f3, a, r));
    end
    tick;
    check("post_done", done_o, 0);
    check("post_busy", busy_o, 0);
    check("post_req", dm.req, 0);
    if (!wr && fc == 2'b00) check("load_hold", rdata_o, exp_load(f3, a, r));
  endtask

  initial begin
    dm.gnt = 0; dm.rvalid = 0; dm.rdata = 0;
    #12;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_cause", fault_cause_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_req", dm.req, 0);
    check("rst_be", dm.be, 0);
    @(negedge clk) rst_n = 1;
    tick;
    xfer(0, 3'b010, 32'h0000_1004, 0, 0, 0, 32'hDEAD_BEEF);
    xfer(0, 3'b000, 32'h0000_1003, 0, 0, 0, 32'h8000_0000);
    xfer(0, 3'b100, 32'h0000_1003, 0, 0, 0, 32'h8000_0000);
    xfer(1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, 0, 0);
    xfer(0, 3'b101, 32'h0000_3002, 0, 1, 2, 32'h9876_5432);
    xfer(0, 3'b010, 32'h0000_1002, 0, 0, 0, 0);
    xfer(1, 3'b001, 32'h0000_1001, 32'h5555_5555, 0, 0, 0);
    xfer(0, 3'b011, 32'h0000_1001, 0, 0, 0, 0);
    xfer(1, 3'b100, 32'h0000_1000, 0, 0, 0, 0);
    xfer(0, 3'b010, 32'h0000_4000, 0, 0, 3, 32'hCAFE_F00D);
    // START with neither or both directions must be ignored
    for (int k = 0; k < 2; k++) begin
      start_i = 1; mem_read_i = k[0]; mem_write_i = k[0]; funct3_i = 3'b010; addr_i = 32'h100;
      tick;
      start_i = 0; mem_read_i = 0; mem_write_i = 0;
      check("ign_busy", busy_o, 0);
      check("ign_req", dm.req, 0);
    end
    // reset asserted while waiting for rvalid aborts without DONE
    start_i = 1; mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h1004;
    tick;
    start_i = 0; mem_read_i = 0; dm.gnt = 1;
    tick;
    dm.gnt = 0;
    check("abort_in_wait", busy_o, 1);
    rst_n = 0;
    #1;
    check("abort_req", dm.req, 0);
    check("abort_busy", busy_o, 0);
    for (int k = 0; k < 3; k++) begin
      check("abort_nodone", done_o, 0);
      tick;
    end
    @(negedge clk) rst_n = 1;
    tick;
    xfer(0, 3'b010, 32'h0000_1004, 0, 0, 1, 32'h0123_4567);
`ifdef LSU_TIMEOUT_EN
    start_i = 1; mem_read_i = 1; funct3_i = 3'b010; addr_i = 32'h2000;
    tick;
    start_i = 0; mem_read_i = 0; dm.gnt = 1;
    tick;
    dm.gnt = 0;
    for (int k = 0; k < 4; k++) begin
      check("tmo_wait", done_o, 0);
      tick;
    end
    check("tmo_done", done_o, 1);
    check("tmo_fault", fault_o, 1);
    check("tmo_cause", fault_cause_o, 2'b11);
    check("tmo_rdata", rdata_o, 0);
    tick;
`endif
    for (int t = 0; t < 60; t++) begin
      bit wr = 1'($urandom % 2);
      logic [2:0] f3 = (t % 4 == 0) ? 3'($urandom) : (wr ? 3'($urandom_range(0, 2)) : 3'({$urandom_range(0, 1), 2'b00} | 3'($urandom_range(0, 2))));
      logic [31:0] a = $urandom;
      if (t % 3 != 0) a = a & ~(32'(size_of(f3)) - 1);
      xfer(wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
